alu_seq: RTL and testbench

Parametrised, handshaked successor to the single-cycle combinational ALU. It adds a registered result, valid/ready flow control on both sides, and iterative multi-cycle MUL, DIVU and REMU operations. It sits between the register-read stage and writeback, and may stall the pipeline via `in_ready` while a multi-cycle operation is running.

---
 rtl/alu_seq.sv | 208 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with a registered result. Single-cycle ops answer
// on the cycle after accept. MUL (shift-add), DIVU and REMU (restoring
// division) iterate one step per cycle for WIDTH cycles.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             resetn,     // synchronous, active-high despite the name
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       aluop_in,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rd,
    output logic [3:0]       flag
);

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SEXT = 4'b1001;
    localparam logic [3:0] OP_ZEXT = 4'b1010;
    localparam logic [3:0] OP_XOR  = 4'b1011;
    localparam logic [3:0] OP_NEG  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1101;
    localparam logic [3:0] OP_DIVU = 4'b1110;
    localparam logic [3:0] OP_REMU = 4'b1111;

    localparam int HALF = WIDTH / 2;
    // Counter value during the final iteration; the result is registered on
    // that same edge so the multi-cycle latency is WIDTH+1 counted like the
    // single-cycle latency of 1.
    localparam logic [SHW:0] LAST_ITER = (SHW+1)'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [SHW:0]       cnt_reg, cnt_next;
    logic [3:0]         op_reg, op_next;
    logic [WIDTH-1:0]   opb_reg, opb_next;     // multiplicand or divisor
    logic [2*WIDTH-1:0] acc_reg, acc_next;     // MUL product / DIV dividend->quotient in low half
    logic [WIDTH:0]     rem_reg, rem_next;     // partial remainder
    logic [WIDTH-1:0]   rd_reg, rd_next;
    logic [3:0]         flag_reg, flag_next;

    logic               accept;
    logic               is_multi;
    logic [WIDTH+3:0]   single_res;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ge;
    logic [WIDTH:0]     div_rem_step;
    logic [WIDTH-1:0]   div_quo_step;
    logic               div_zero;

    // Result {rd, flag} of every single-cycle opcode; 0000 and anything not
    // handled here yields the illegal-opcode answer.
    function automatic logic [WIDTH+3:0] single_op(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        logic [3:0]       f;
        logic [WIDTH:0]   sum;
        logic [SHW-1:0]   sh;
        r   = '0;
        f   = 4'b0000;
        sum = {1'b0, a} + {1'b0, b};
        sh  = b[SHW-1:0];
        case (op)
            OP_ADD:  begin r = sum[WIDTH-1:0]; f[1] = sum[WIDTH]; end
            OP_SUB:  begin r = a - b; f[0] = (a < b); end
            OP_AND:  r = a & b;
            OP_SLL:  r = a << sh;
            OP_SRL:  r = a >> sh;
            OP_SRA:  r = WIDTH'($signed(a) >>> sh);
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SEXT: r = {{(WIDTH-HALF){a[HALF-1]}}, a[HALF-1:0]};
            OP_ZEXT: r = {{(WIDTH-HALF){1'b0}}, a[HALF-1:0]};
            OP_XOR:  r = a ^ b;
            OP_NEG:  r = '0 - a;
            default: f = 4'b0100;
        endcase
        return {r, f};
    endfunction

    assign in_ready  = resetn || (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
    assign out_valid = (state_reg == DONE);
    assign rd        = rd_reg;
    assign flag      = flag_reg;

    assign accept     = in_valid && in_ready;
    assign is_multi   = (aluop_in == OP_MUL) || (aluop_in == OP_DIVU) || (aluop_in == OP_REMU);
    assign single_res = single_op(aluop_in, rs1, rs2);

    // One shift-add multiply step and one restoring-division step from the current working registers.
    always_comb begin
        mul_sum      = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opb_reg} : '0);
        mul_step     = {mul_sum, acc_reg[WIDTH-1:1]};
        div_diff     = {rem_reg, acc_reg[WIDTH-1]} - {2'b00, opb_reg};
        div_ge       = ~div_diff[WIDTH+1];
        div_rem_step = div_ge ? div_diff[WIDTH:0] : {rem_reg[WIDTH-1:0], acc_reg[WIDTH-1]};
        div_quo_step = {acc_reg[WIDTH-2:0], div_ge};
        div_zero     = (opb_reg == '0);
    end

    // Next-state and datapath control: accept, iterate, finalize, hand off.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        opb_next   = opb_reg;
        acc_next   = acc_reg;
        rem_next   = rem_reg;
        rd_next    = rd_reg;
        flag_next  = flag_reg;
        if (accept) begin
            if (is_multi) begin
                op_next    = aluop_in;
                opb_next   = rs2;
                acc_next   = {{WIDTH{1'b0}}, rs1};
                rem_next   = '0;
                cnt_next   = '0;
                state_next = BUSY;
            end else begin
                rd_next    = single_res[WIDTH+3:4];
                flag_next  = single_res[3:0];
                state_next = DONE;
            end
        end else begin
            case (state_reg)
                BUSY: begin
                    cnt_next = cnt_reg + 1'b1;
                    if (op_reg == OP_MUL) begin
                        acc_next = mul_step;
                    end else begin
                        acc_next = {acc_reg[2*WIDTH-1:WIDTH], div_quo_step};
                        rem_next = div_rem_step;
                    end
                    if (cnt_reg == LAST_ITER) begin
                        state_next = DONE;
                        case (op_reg)
                            OP_MUL: begin
                                rd_next   = mul_step[WIDTH-1:0];
                                flag_next = {2'b00, |mul_step[2*WIDTH-1:WIDTH], 1'b0};
                            end
                            OP_DIVU: begin
                                rd_next   = div_zero ? '1 : div_quo_step;
                                flag_next = div_zero ? 4'b1000 : 4'b0000;
                            end
                            default: begin
                                // With a zero divisor the remainder walks out equal to rs1.
                                rd_next   = div_rem_step[WIDTH-1:0];
                                flag_next = div_zero ? 4'b1000 : 4'b0000;
                            end
                        endcase
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_next = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            op_reg    <= '0;
            opb_reg   <= '0;
            acc_reg   <= '0;
            rem_reg   <= '0;
            rd_reg    <= '0;
            flag_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
            opb_reg   <= opb_next;
            acc_reg   <= acc_next;
            rem_reg   <= rem_next;
            rd_reg    <= rd_next;
            flag_reg  <= flag_next;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: the driver pushes expected results at
// accept, a monitor pops and compares when the DUT presents them.
module tb_alu_seq;

    localparam int W    = 16;
    localparam int MLAT = W + 1;

    logic         clk = 1'b0;
    logic         resetn = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   aluop_in = 4'd0;
    logic [W-1:0] rs1 = '0;
    logic [W-1:0] rs2 = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] rd;
    logic [3:0]   flag;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluop_in  (aluop_in),
        .rs1       (rs1),
        .rs2       (rs2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd        (rd),
        .flag      (flag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] rd;
        logic [3:0]   flag;
        int           acc;
        int           lat;
    } exp_t;

    exp_t q[$];
    bit   mon_en  = 1'b0;
    bit   rand_bp = 1'b0;
    int   last_acc = 0;

    // Reference model written with plain wide arithmetic.
    function automatic logic [19:0] model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        logic [15:0] r;
        logic [3:0]  f;
        int          sh;
        r  = 16'h0;
        f  = 4'b0000;
        sh = int'(b % 16);
        p  = 32'(a) + 32'(b);
        case (op)
            4'd1:  begin r = p[15:0]; f[1] = p[16]; end
            4'd2:  begin r = a - b; f[0] = (a < b); end
            4'd3:  r = a & b;
            4'd4:  r = a << sh;
            4'd5:  r = a >> sh;
            4'd6:  r = 16'($signed(a) >>> sh);
            4'd7:  r = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            4'd8:  r = (a < b) ? 16'd1 : 16'd0;
            4'd9:  r = {{8{a[7]}}, a[7:0]};
            4'd10: r = {8'h00, a[7:0]};
            4'd11: r = a ^ b;
            4'd12: r = 16'd0 - a;
            4'd13: begin p = 32'(a) * 32'(b); r = p[15:0]; f[1] = (p[31:16] != 0); end
            4'd14: begin if (b == 0) begin r = 16'hFFFF; f = 4'b1000; end else r = a / b; end
            4'd15: begin if (b == 0) begin r = a; f = 4'b1000; end else r = a % b; end
            default: f = 4'b0100;
        endcase
        return {r, f};
    endfunction

    task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] e_rd, input logic [3:0] e_flag);
        exp_t e;
        int   w;
        w = 0;
        @(negedge clk);
        aluop_in = op;
        rs1      = a;
        rs2      = b;
        in_valid = 1'b1;
        #1;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (w >= 200) check("accept_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e.op   = op;
        e.rd   = e_rd;
        e.flag = e_flag;
        e.acc  = cyc;
        e.lat  = (op >= 4'd13) ? MLAT : 1;
        q.push_back(e);
        last_acc = cyc;
    endtask

    task automatic send_m(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [19:0] m;
        m = model(op, a, b);
        send(op, a, b, m[19:4], m[3:0]);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("drain_timeout", q.size(), 0);
    endtask

    // Random back-pressure on the result side.
    always @(negedge clk) begin
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    end

    logic         prev_valid = 1'b0;
    logic         prev_taken = 1'b0;
    logic [W-1:0] prev_rd = '0;
    logic [3:0]   prev_flag = '0;

    // Monitor: handshake rules every cycle, scoreboard compare on each new result.
    always begin
        exp_t e;
        logic exp_ir;
        @(negedge clk);
        #2;
        if (mon_en) begin
            exp_ir = out_valid ? out_ready : (q.size() == 0);
            check("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
            if (prev_valid && !prev_taken) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_rd", {16'd0, rd}, {16'd0, prev_rd});
                check("hold_flag", {28'd0, flag}, {28'd0, prev_flag});
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = q[0];
                    if (!prev_valid || prev_taken) begin
                        check("latency", cyc - e.acc + 1, e.lat);
                        check("rd", {16'd0, rd}, {16'd0, e.rd});
                        check("flag", {28'd0, flag}, {28'd0, e.flag});
                    end
                    if (out_ready) begin
                        void'(q.pop_front());
                        $display("txn op=%b rd=%h flag=%b exp_rd=%h exp_flag=%b t=%0t",
                                 e.op, rd, flag, e.rd, e.flag, $time);
                    end
                end
            end
            prev_valid = out_valid;
            prev_taken = out_valid && out_ready;
            prev_rd    = rd;
            prev_flag  = flag;
        end
    end

    initial begin
        int pa;
        logic [3:0]  op;
        logic [15:0] a, b;

        // Reset state
        repeat (2) @(negedge clk);
        #3;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_rd", {16'd0, rd}, 32'd0);
        check("rst_flag", {28'd0, flag}, 32'd0);
        @(negedge clk);
        resetn = 1'b0;
        mon_en = 1'b1;

        // Add/sub flags
        send(4'd1, 16'hFFFF, 16'h0001, 16'h0000, 4'b0010);
        send(4'd2, 16'h0003, 16'h0005, 16'hFFFE, 4'b0001);

        // Multiply
        send(4'd13, 16'h0100, 16'h0101, 16'h0100, 4'b0010);
        send(4'd13, 16'h0012, 16'h0003, 16'h0036, 4'b0000);

        // Divide / remainder including divide-by-zero
        send(4'd14, 16'h0064, 16'h0007, 16'h000E, 4'b0000);
        send(4'd15, 16'h0064, 16'h0007, 16'h0002, 4'b0000);
        send(4'd14, 16'h1234, 16'h0000, 16'hFFFF, 4'b1000);
        send(4'd15, 16'h1234, 16'h0000, 16'h1234, 4'b1000);

        // Back-pressure then back-to-back adds
        drain();
        out_ready = 1'b0;
        send(4'd11, 16'hAAAA, 16'h0F0F, 16'hA5A5, 4'b0000);
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pa = last_acc;
            send_m(4'd1, 16'(i * 16'h1111), 16'(16'h0F00 + i));
            if (i > 0) check("b2b_gap", cyc - pa, 1);
        end

        // Shifts, extends, compares
        send(4'd6, 16'h8000, 16'h0013, 16'hF000, 4'b0000);
        send(4'd4, 16'h0001, 16'h000F, 16'h8000, 4'b0000);
        send(4'd9, 16'h0080, 16'h0000, 16'hFF80, 4'b0000);
        send(4'd10, 16'h1280, 16'h0000, 16'h0080, 4'b0000);
        send(4'd7, 16'hFFFF, 16'h0001, 16'h0001, 4'b0000);
        send(4'd8, 16'hFFFF, 16'h0001, 16'h0000, 4'b0000);
        drain();

        // Reset in the middle of a divide
        send(4'd14, 16'h0064, 16'h0007, 16'h000E, 4'b0000);
        repeat (8) @(negedge clk);
        resetn = 1'b1;
        q.delete();
        @(negedge clk);
        resetn = 1'b0;
        #3;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_rd", {16'd0, rd}, 32'd0);
        check("midrst_flag", {28'd0, flag}, 32'd0);
        repeat (30) @(negedge clk);

        // Illegal opcode
        send(4'd0, 16'h1234, 16'h5678, 16'h0000, 4'b0100);
        drain();

        // Random mix with random back-pressure
        rand_bp = 1'b1;
        repeat (40) begin
            op = 4'($urandom_range(0, 15));
            a  = 16'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            send_m(op, a, b);
        end
        rand_bp = 1'b0;
        out_ready = 1'b1;
        drain();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
